// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: SPI transaction sequencer framing an opcode phase and a snapshotted reply phase.
module spi_txn_ctrl #(
  parameter int NBITS   = 24,
  parameter int OPBITS  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        sck,
  input  logic [7:0]  opcode_in,
  input  logic [23:0] game_reply,
  input  logic [23:0] stat_reply,
  output logic        done,
  output logic [23:0] reply_out,
  output logic [7:0]  op_code,
  output logic        op_valid,
  output logic        txn_done,
  output logic        err_frame,
  output logic        err_opcode,
  output logic        err_timeout
);
  localparam int BW = $clog2(NBITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] OP_N   = BW'(OPBITS);
  localparam logic [BW-1:0] OP_SAT = BW'(OPBITS + 1);
  localparam logic [BW-1:0] NB_L   = BW'(NBITS - 1);
  localparam logic [TW-1:0] TO_N   = TW'(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DECODE, S_REPLY, S_END} state_t;
  state_t state;
  logic load_m, load_s, load_q, sck_m, sck_s, sck_q;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic sck_rise;
  assign sck_rise = sck_s & ~sck_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      {load_m, load_s, load_q, sck_m, sck_s, sck_q} <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      done        <= 1'b0;
      reply_out   <= '0;
      op_code     <= '0;
      op_valid    <= 1'b0;
      txn_done    <= 1'b0;
      err_frame   <= 1'b0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      {load_m, load_s, load_q} <= {load, load_m, load_s};
      {sck_m, sck_s, sck_q}    <= {sck, sck_m, sck_s};
      op_valid    <= 1'b0;
      txn_done    <= 1'b0;
      err_frame   <= 1'b0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt <= (state != S_REPLY || sck_rise) ? '0 : (to_cnt == TO_N ? to_cnt : to_cnt + TW'(1));
      case (state)
        S_IDLE: if (load_s) begin
          state   <= S_LOAD;
          bit_cnt <= '0;
        end
        S_LOAD: if (!load_s) begin
          state     <= bit_cnt == OP_N ? S_DECODE : S_IDLE;
          err_frame <= bit_cnt != OP_N;
          bit_cnt   <= '0;
        end else if (sck_rise && bit_cnt != OP_SAT) bit_cnt <= bit_cnt + BW'(1);
        S_DECODE: begin
          state      <= S_REPLY;
          done       <= 1'b1;
          op_valid   <= 1'b1;
          op_code    <= opcode_in;
          reply_out  <= opcode_in[7] ? 24'h0 : opcode_in[6] ? stat_reply : game_reply;
          err_opcode <= opcode_in[7];
          bit_cnt    <= '0;
        end
        // abort beats completion, completion beats timeout
        S_REPLY: if (load_s && !load_q) begin
          state   <= S_LOAD;
          done    <= 1'b0;
          bit_cnt <= '0;
        end else if (sck_rise && bit_cnt == NB_L) begin
          state    <= S_END;
          done     <= 1'b0;
          txn_done <= 1'b1;
          bit_cnt  <= '0;
        end else if (to_cnt == TO_N) begin
          state       <= S_IDLE;
          done        <= 1'b0;
          err_timeout <= 1'b1;
          bit_cnt     <= '0;
        end else if (sck_rise) bit_cnt <= bit_cnt + BW'(1);
        S_END: begin
          state   <= load_s ? S_LOAD : S_IDLE;
          bit_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: scoreboard bench for spi_txn_ctrl with directed transactions.
module tb_spi_txn_ctrl;
  localparam int K_NONE = 0, K_OPV = 1, K_EOP = 2, K_TXN = 3, K_FRM = 4, K_TMO = 5;
  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [23:0] rep;
    logic        eop;
  } ev_t;
  logic clk = 1'b0, reset, load, sck;
  logic [7:0] opcode_in;
  logic [23:0] game_reply, stat_reply, reply_out;
  logic [7:0] op_code;
  logic done, op_valid, txn_done, err_frame, err_opcode, err_timeout;
  int checks = 0, failures = 0, rep_bad = 0;
  logic [23:0] exp_rep = '0;
  ev_t sb[$];

  spi_txn_ctrl #(.NBITS(24), .OPBITS(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .load(load), .sck(sck), .opcode_in(opcode_in),
    .game_reply(game_reply), .stat_reply(stat_reply), .done(done),
    .reply_out(reply_out), .op_code(op_code), .op_valid(op_valid),
    .txn_done(txn_done), .err_frame(err_frame), .err_opcode(err_opcode),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input logic [7:0] op, input logic [23:0] rep);
    ev_t e;
    e.kind = kind;
    e.op   = op;
    e.rep  = rep;
    e.eop  = op[7];
    sb.push_back(e);
  endtask

  task automatic sck_edges(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
      tick(3);
    end
  endtask

  task automatic opcode_phase(input logic [7:0] op, input int n);
    opcode_in = op;
    load = 1'b1;
    tick(4);
    sck_edges(n);
    load = 1'b0;
    tick(6);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  function automatic logic [23:0] src(input logic [7:0] op);
    return op[7] ? 24'h0 : op[6] ? stat_reply : game_reply;
  endfunction

  // n==24 completes normally; a shorter n stalls and must time out
  task automatic txn(input logic [7:0] op, input int n, input bit chg);
    int c;
    push(K_OPV, op, src(op));
    push(n == 24 ? K_TXN : K_TMO, op, 24'h0);
    opcode_phase(op, 8);
    chk("done_high_in_reply", 32'(done), 1);
    if (chg) begin
      sck_edges(12);
      stat_reply = 24'hFFFFFF;
      game_reply = ~game_reply;
      sck_edges(n - 13);
    end else sck_edges(n - 1);
    chk("done_high_before_last_edge", 32'(done), 1);
    if (n == 24) sck_edges(1);
    else begin
      sck = 1'b1;
      c = 0;
      while (!err_timeout && c < 40) begin
        tick(1);
        c++;
      end
      checks++;
      if (c < 19 || c > 21) begin
        failures++;
        $display("FAIL timeout_latency actual=%0d expected=19..21", c);
      end
      sck = 1'b0;
      tick(2);
    end
    chk("done_low_after_txn", 32'(done), 0);
    drain();
  endtask

  task automatic mon();
    ev_t e;
    int k;
    if (done && reply_out !== exp_rep) rep_bad++;
    if (!(op_valid | txn_done | err_frame | err_opcode | err_timeout)) return;
    k = op_valid ? K_OPV : err_opcode ? K_EOP : txn_done ? K_TXN : err_frame ? K_FRM : K_TMO;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", 32'(k), K_NONE);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 32'(k), 32'(e.kind));
    if (k == K_OPV && e.kind == K_OPV) begin
      chk("op_code", 32'(op_code), 32'(e.op));
      chk("reply_out", 32'(reply_out), 32'(e.rep));
      chk("err_opcode_with_op_valid", 32'(err_opcode), 32'(e.eop));
      exp_rep = e.rep;
      rep_bad = 0;
    end
    if (e.kind == K_TXN) chk("reply_unstable_cycles", 32'(rep_bad), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    reset = 1'b1; load = 1'b0; sck = 1'b0; opcode_in = 8'h0;
    game_reply = 24'hA5C30F; stat_reply = 24'h000123;
    tick(3);
    chk("rst_done", 32'(done), 0);
    chk("rst_reply_out", 32'(reply_out), 0);
    chk("rst_op_code", 32'(op_code), 0);
    chk("rst_pulses", 32'({op_valid, txn_done, err_frame, err_opcode, err_timeout}), 0);
    reset = 1'b0;
    tick(2);
    txn(8'h05, 24, 0);
    txn(8'h41, 24, 1);
    push(K_FRM, 8'h05, 24'h0);
    opcode_phase(8'h05, 7);
    chk("done_low_after_bad_frame", 32'(done), 0);
    drain();
    game_reply = 24'h123456;
    txn(8'h05, 24, 0);
    txn(8'hC0, 24, 0);
    txn(8'h05, 10, 0);
    stat_reply = 24'h00BEEF;
    push(K_OPV, 8'h05, game_reply);
    push(K_OPV, 8'h41, 24'h00BEEF);
    push(K_TXN, 8'h41, 24'h0);
    opcode_phase(8'h05, 8);
    sck_edges(12);
    opcode_in = 8'h41;
    load = 1'b1;
    tick(4);
    chk("done_low_after_abort", 32'(done), 0);
    sck_edges(8);
    load = 1'b0;
    tick(6);
    chk("done_high_after_reopen", 32'(done), 1);
    sck_edges(24);
    chk("done_low_after_reopen_txn", 32'(done), 0);
    drain();
    push(K_OPV, 8'h41, 24'h00BEEF);
    opcode_phase(8'h41, 8);
    sck_edges(5);
    drain();
    reset = 1'b1;
    tick(1);
    chk("midreply_rst_done", 32'(done), 0);
    chk("midreply_rst_reply_out", 32'(reply_out), 0);
    chk("midreply_rst_op_code", 32'(op_code), 0);
    reset = 1'b0;
    tick(2);
    game_reply = 24'h0F0F0F;
    txn(8'h05, 24, 0);
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
